// File: rtl/dsm_pkg.sv
// Shared types and helpers for the delta-sigma DAC sequencer.
package dsm_pkg;

    localparam int unsigned DsmDataWidth = 16;
    localparam int unsigned DsmOsrWidth  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StRun,
        StRamp
    } dsm_state_e;

    // Moves v toward zero by step without crossing it. The 32-bit operands leave headroom
    // above the sample width, so the most negative sample neither wraps nor overshoots.
    function automatic logic signed [31:0] ramp_toward_zero(
        input logic signed [31:0] v,
        input logic signed [31:0] step
    );
        logic signed [31:0] r;
        if (v > step) begin
            r = v - step;
        end else if (v < -step) begin
            r = v + step;
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsm_period_counter.sv
// Oversampling period counter: counts 0..osr while enabled and flags the last clock of each period.
module dsm_period_counter #(
    parameter int unsigned OSR_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [OSR_WIDTH-1:0] osr_i,
    output logic                 tick_o,
    output logic                 tick_next_o
);

    logic [OSR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == osr_i);
        cnt_d  = cnt_q;
        if (load_i || !en_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Lets the owner open its input a clock early when the next cycle will consume.
        tick_next_o = (cnt_d == osr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dsm_dac_sequencer.sv
// Sample-rate scheduler and power sequencer feeding a delta-sigma DAC: settle on start,
// one sample per oversampling period in run, click-free ramp to zero on stop.
module dsm_dac_sequencer
    import dsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DsmDataWidth,
    parameter int unsigned OSR_WIDTH    = DsmOsrWidth,
    parameter int unsigned SETTLE_TICKS = 4,
    parameter int unsigned RAMP_STEP    = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [OSR_WIDTH-1:0]  i_osr,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_dac_en,
    output logic [DATA_WIDTH-1:0] o_dac_data,
    output logic                  o_busy,
    output logic                  o_underrun
);

    localparam int unsigned SettleW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_TICKS - 1);

    dsm_state_e            state_q, state_d;
    logic [OSR_WIDTH-1:0]  osr_q, osr_d;
    logic [SettleW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  ready_q, ready_d;
    logic                  dac_en_q, dac_en_d;
    logic [DATA_WIDTH-1:0] dac_data_q, dac_data_d;
    logic                  underrun_q, underrun_d;

    logic                  tick, tick_next, load_cnt, accept, do_load, will_consume;
    logic signed [31:0]    dac_wide, ramp_wide;

    dsm_period_counter #(
        .OSR_WIDTH(OSR_WIDTH)
    ) u_period_counter (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .en_i       (state_q != StIdle),
        .load_i     (load_cnt),
        .osr_i      (osr_q),
        .tick_o     (tick),
        .tick_next_o(tick_next)
    );

    assign accept    = i_s_valid && ready_q;
    assign dac_wide  = 32'($signed(dac_data_q));
    assign ramp_wide = ramp_toward_zero(dac_wide, $signed(32'(RAMP_STEP)));

    always_comb begin
        state_d      = state_q;
        osr_d        = osr_q;
        settle_cnt_d = settle_cnt_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        dac_en_d     = dac_en_q;
        dac_data_d   = dac_data_q;
        underrun_d   = underrun_q;
        load_cnt     = 1'b0;
        do_load      = 1'b0;

        case (state_q)
            StIdle: begin
                dac_en_d    = 1'b0;
                dac_data_d  = '0;
                buf_valid_d = 1'b0;
                if (i_start) begin
                    osr_d        = i_osr;
                    underrun_d   = 1'b0;
                    settle_cnt_d = '0;
                    load_cnt     = 1'b1;
                    dac_en_d     = 1'b1;
                    state_d      = StSettle;
                end
            end
            StSettle, StRun: begin
                if (accept) begin
                    buf_d       = i_s_data;
                    buf_valid_d = 1'b1;
                end
                if (i_stop) begin
                    state_d     = StRamp;
                    buf_valid_d = 1'b0;
                end else if (tick) begin
                    if (state_q == StRun) begin
                        do_load = 1'b1;
                    end else if (settle_cnt_q == SettleLast) begin
                        state_d = StRun;
                        do_load = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                if (do_load) begin
                    if (buf_valid_q) begin
                        dac_data_d  = buf_q;
                        // A sample accepted on the consuming clock refills the entry.
                        buf_valid_d = accept;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            StRamp: begin
                buf_valid_d = 1'b0;
                if (tick) begin
                    if (dac_data_q == '0) begin
                        state_d  = StIdle;
                        dac_en_d = 1'b0;
                    end else begin
                        dac_data_d = ramp_wide[DATA_WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        will_consume = tick_next && ((state_d == StRun) ||
                                     ((state_d == StSettle) && (settle_cnt_d == SettleLast)));
        ready_d = ((state_d == StSettle) || (state_d == StRun)) && (!buf_valid_d || will_consume);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            osr_q        <= '0;
            settle_cnt_q <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            ready_q      <= 1'b0;
            dac_en_q     <= 1'b0;
            dac_data_q   <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            osr_q        <= osr_d;
            settle_cnt_q <= settle_cnt_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            ready_q      <= ready_d;
            dac_en_q     <= dac_en_d;
            dac_data_q   <= dac_data_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_s_ready  = ready_q;
    assign o_dac_en   = dac_en_q;
    assign o_dac_data = dac_data_q;
    assign o_busy     = (state_q != StIdle);
    assign o_underrun = underrun_q;

endmodule

// File: doc/dsm_dac_sequencer.md
Name: dsm_dac_sequencer

Overview:
Sample-rate scheduler and power sequencer for the delta-sigma DAC datapath. It accepts PCM samples over a valid/ready stream and presents them to the DAC at one sample per oversampling period, with exactly OSR modulator clocks per sample. It gates the DAC enable, settles the modulator on start, and ramps the output to zero on stop so that stopping produces no step. It sits between the audio/sample source and the DAC's i_en/i_data inputs.

Parameters:
DATA_WIDTH, 16, sample width (signed two's complement); must match the DAC.
OSR_WIDTH, 10, width of the oversampling-period configuration.
SETTLE_TICKS, 4, sample periods of zero data driven after start, before RUN.
RAMP_STEP, 256, magnitude decrement per sample period during ramp-down (positive, < 2^(DATA_WIDTH-1)).

Ports:
i_clk  in  1  modulator clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle start request
i_stop  in  1  single-cycle stop request
i_osr  in  OSR_WIDTH  sample period minus one, in clocks; captured on accepted start
i_s_valid  in  1  input sample valid
o_s_ready  out  1  input sample ready
i_s_data  in  DATA_WIDTH  signed input sample
o_dac_en  out  1  to DAC i_en
o_dac_data  out  DATA_WIDTH  to DAC i_data (signed)
o_busy  out  1  state != IDLE
o_underrun  out  1  sticky underrun flag

Behaviour:
- Clock and reset: single clock i_clk; i_rst_n asynchronous active-low. All flops reset: state=IDLE, counters=0, osr_q=0, hold buffer empty, o_dac_en=0, o_dac_data=0, o_s_ready=0, o_busy=0, o_underrun=0.
- Reset mid-operation: everything returns to the reset values immediately. The buffered sample is discarded.
- Period counter: a free-running counter runs in all non-IDLE states, counting 0..osr_q. tick=1 when cnt==osr_q, and cnt then wraps to 0. osr_q=0 gives a tick every clock. i_osr changes are ignored until the next accepted start.
- Hold buffer: one entry, registered. Accept happens when i_s_valid & o_s_ready. o_s_ready = (state==SETTLE or RUN) & buffer empty, registered so it has no combinational path from valid. The buffer is freed on the tick that consumes it.
- Outputs: o_dac_data is registered and changes only on a tick, or on IDLE entry. o_dac_en is registered.
- State IDLE:
  - o_dac_en=0, o_dac_data=0.
  - On i_start: capture osr_q=i_osr, clear o_underrun and cnt, go to SETTLE. o_dac_en=1 from the next clock.
  - i_stop in IDLE is ignored.
- State SETTLE:
  - o_dac_data=0; the buffer may fill.
  - After SETTLE_TICKS ticks, go to RUN. That same tick already performs the RUN load rule.
- State RUN, on each tick:
  - Buffer full: o_dac_data=buffer, buffer emptied.
  - Buffer empty: o_dac_data holds its previous value and o_underrun is set (sticky until the next start).
- i_stop in SETTLE or RUN: go to RAMP. The buffer is flushed and o_s_ready drops the next clock. The stop pulse is latched, not lost between ticks.
- State RAMP, on each tick:
  - If |o_dac_data| <= RAMP_STEP: o_dac_data becomes 0.
  - Otherwise: o_dac_data moves toward 0 by RAMP_STEP. The arithmetic is done at DATA_WIDTH+1 bits, with no overshoot and no wrap; the most negative value is handled.
  - On the first tick where o_dac_data is already 0: go to IDLE, o_dac_en=0.
- Simultaneous start and stop in IDLE: start wins. In other states start is ignored and stop applies.
- Latency: an accepted sample appears on o_dac_data at the first tick after acceptance, worst case osr_q+1 clocks.

Decomposition:
- Package dsm_pkg: state enum (IDLE, SETTLE, RUN, RAMP), default DATA_WIDTH/OSR_WIDTH constants, and a saturating ramp-toward-zero function.
- One sub-module, dsm_period_counter (enable, load, osr → tick). FSM, buffer and ramp stay inline.

Test Plan:
1. Reset check: assert i_rst_n=0 mid-RUN with buffer full → all outputs 0 immediately; o_s_ready=0 after release.
2. Start, i_osr=3, SETTLE_TICKS=4, samples 1000, -2000 always valid → o_dac_en rises the clock after start; data=0 for 16 clocks; then 1000 for exactly 4 clocks, then -2000; o_underrun=0.
3. Underrun: in RUN, withhold valid for 2 periods after sample 500 → o_dac_data holds 500 across 12 clocks; o_underrun=1 until the next start.
4. Stop from o_dac_data=600, RAMP_STEP=256 → tick sequence 344, 88, 0, then o_dac_en=0 one period later. From -32768: -32512, … to 0 with no wrap.
5. i_osr=0 → new sample every clock with ready sustained; back-to-back accept with no bubbles. Repeat with i_osr=1023 and check the period is 1024 clocks.
6. Start and stop in the same clock in IDLE → enters SETTLE. Stop pulse mid-period (cnt=1 of 3) → RAMP entered; first ramp step at the next tick.
